// File: rtl/slide_pot_intf.sv
// SPI master that round-robin polls six slide pots on an ADC128S-style A2D
// and holds the latest 12-bit reading of each on its own output.
module slide_pot_intf (
  input  logic        clk,
  input  logic        rst_n,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] VOLUME
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_GAP, S_READ, S_WRITE} state_t;

  // Preload leaves SCLK high and puts the first falling edge 9 clocks after SS_n falls.
  localparam logic [4:0] DIV_PRELOAD = 5'b10111;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_div;
  logic [4:0]  r_rise_cnt;
  logic [15:0] r_tx;
  logic [15:0] r_rx;
  logic        r_sample;
  logic        r_ss_n;
  logic [2:0]  r_idx;
  logic [11:0] r_pot [6];

  logic        w_active;
  logic        w_rise;
  logic        w_fall;
  logic        w_last;
  logic        w_start;
  logic        w_write;
  logic [15:0] w_start_word;
  logic [2:0]  w_chan;

  // Sequencer slot to A2D channel: LP, B1, B2, B3, HP, VOLUME.
  always_comb begin
    w_chan = 3'd1;
    case (r_idx)
      3'd0:    w_chan = 3'd1;
      3'd1:    w_chan = 3'd0;
      3'd2:    w_chan = 3'd4;
      3'd3:    w_chan = 3'd2;
      3'd4:    w_chan = 3'd3;
      3'd5:    w_chan = 3'd7;
      default: w_chan = 3'd1;
    endcase
  end

  assign w_active = ~r_ss_n;
  assign w_rise   = w_active && (r_div == 5'b01111);
  assign w_last   = w_active && (r_div == 5'b11111) && (r_rise_cnt == 5'd16);
  assign w_fall   = w_active && (r_div == 5'b11111) && (r_rise_cnt != 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_start_word = 16'h0000;
    w_write      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start      = 1'b1;
        w_start_word = {2'b00, w_chan, 11'b0};
        w_state_next = S_CMD;
      end
      S_CMD:   if (w_last) w_state_next = S_GAP;
      S_GAP: begin
        w_start      = 1'b1;
        w_state_next = S_READ;
      end
      S_READ:  if (w_last) w_state_next = S_WRITE;
      S_WRITE: begin
        w_write      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n     <= 1'b1;
      r_div      <= DIV_PRELOAD;
      r_rise_cnt <= 5'd0;
      r_tx       <= 16'h0000;
      r_rx       <= 16'h0000;
      r_sample   <= 1'b0;
    end else if (w_start) begin
      r_ss_n     <= 1'b0;
      r_div      <= DIV_PRELOAD;
      r_rise_cnt <= 5'd0;
      r_tx       <= w_start_word;
    end else if (w_active) begin
      if (w_last) begin
        // Final shift happens without a 17th SCLK fall; SCLK stays high.
        r_ss_n <= 1'b1;
        r_div  <= DIV_PRELOAD;
        r_tx   <= {r_tx[14:0], 1'b0};
        r_rx   <= {r_rx[14:0], r_sample};
      end else begin
        r_div <= r_div + 5'd1;
        if (w_rise) begin
          r_sample   <= MISO;
          r_rise_cnt <= r_rise_cnt + 5'd1;
        end
        // The very first fall has no sample behind it, so MOSI keeps bit 15.
        if (w_fall && (r_rise_cnt != 5'd0)) begin
          r_tx <= {r_tx[14:0], 1'b0};
          r_rx <= {r_rx[14:0], r_sample};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 3'd0;
      for (int i = 0; i < 6; i++) r_pot[i] <= 12'h000;
    end else if (w_write) begin
      r_pot[r_idx] <= r_rx[11:0];
      r_idx        <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end
  end

  assign SS_n   = r_ss_n;
  assign SCLK   = r_div[4];
  assign MOSI   = r_tx[15];
  assign POT_LP = r_pot[0];
  assign POT_B1 = r_pot[1];
  assign POT_B2 = r_pot[2];
  assign POT_B3 = r_pot[3];
  assign POT_HP = r_pot[4];
  assign VOLUME = r_pot[5];

endmodule

// File: tb/tb_slide_pot_intf.sv
// Bench for slide_pot_intf: a behavioural A2D model on the SPI pins plus a
// reference table of expected outputs, checked every clock and at directed steps.
module tb_slide_pot_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;

  int tests = 0;
  int fails = 0;

  logic [11:0] chan_val [8];
  logic [11:0] exp_out  [6];
  logic [11:0] dut_out  [6];
  int          txn_n;
  int          seq;
  logic [2:0]  last_ch;

  // Output slot order LP,B1,B2,B3,HP,VOL and the A2D channel wired to each.
  int          slot_chan [6] = '{1, 0, 4, 2, 3, 7};
  int          chan2out  [8] = '{1, 0, 3, 4, 2, 0, 0, 5};
  logic [15:0] cmd_tab   [6] = '{16'h0800, 16'h0000, 16'h2000, 16'h1000, 16'h1800, 16'h3800};
  string       out_name  [6] = '{"LP", "B1", "B2", "B3", "HP", "VOL"};

  slide_pot_intf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .POT_LP(POT_LP), .POT_B1(POT_B1), .POT_B2(POT_B2), .POT_B3(POT_B3),
    .POT_HP(POT_HP), .VOLUME(VOLUME)
  );

  always #5 clk = ~clk;

  assign dut_out[0] = POT_LP;
  assign dut_out[1] = POT_B1;
  assign dut_out[2] = POT_B2;
  assign dut_out[3] = POT_B3;
  assign dut_out[4] = POT_HP;
  assign dut_out[5] = VOLUME;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txn_n   = 0;
    seq     = 0;
    last_ch = 3'd0;
    for (int i = 0; i < 6; i++) exp_out[i] = 12'h000;
  endtask

  // A2D model: captures commands on SCLK rises, drives MISO on falls.
  // Read transactions return the addressed channel; command transactions return junk.
  initial begin : a2d
    logic [15:0] word, rx;
    int          rises, d;
    bit          aborted, is_read;
    time         t_start, t_rise, t_ss_rise;
    model_reset();
    MISO = 1'b0;
    t_ss_rise = 0;
    t_rise = 0;
    forever begin
      @(negedge SS_n or negedge rst_n);
      if (rst_n !== 1'b1) begin model_reset(); continue; end
      is_read = txn_n[0];
      if (is_read) begin
        d = int'($time - t_ss_rise);
        check("gap_clk_ok", 16'(d >= 10 && d <= 20), 16'd1);
      end
      word    = is_read ? {4'($urandom), chan_val[last_ch]} : 16'($urandom);
      MISO    = word[15];
      rises   = 0;
      rx      = 16'h0000;
      aborted = 1'b0;
      t_start = $time;
      forever begin
        @(posedge SCLK or negedge SCLK or posedge SS_n or negedge rst_n);
        if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
        if (SS_n === 1'b1) break;
        if (SCLK === 1'b1) begin
          rises++;
          rx = {rx[14:0], MOSI};
          if (rises > 1) check("sclk_period", 16'($time - t_rise), 16'd320);
          t_rise = $time;
        end else begin
          if (rises == 0) begin
            d = int'($time - t_start);
            check("front_porch_ok", 16'(d >= 80 && d <= 160), 16'd1);
          end
          if (rises > 0 && rises < 16) MISO = word[15 - rises];
        end
      end
      if (aborted) begin model_reset(); continue; end
      t_ss_rise = $time;
      check("sclk_rises", 16'(rises), 16'd16);
      d = int'($time - t_rise);
      check("back_porch_ok", 16'(d >= 80 && d <= 160), 16'd1);
      if (!is_read) begin
        check("cmd_word", rx, cmd_tab[seq]);
        last_ch = rx[13:11];
      end else begin
        check("mosi_read", rx, 16'h0000);
        @(posedge clk);
        if (rst_n === 1'b1) exp_out[chan2out[last_ch]] = word[11:0];
        seq = (seq + 1) % 6;
      end
      txn_n++;
    end
  end

  // Every clock: outputs match the reference table, and SCLK idles high.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 6; i++)
        check({"hold_", out_name[i]}, {4'h0, dut_out[i]}, {4'h0, exp_out[i]});
      if (SS_n === 1'b1) check("sclk_idle", {15'h0, SCLK}, 16'd1);
    end
  end

  initial begin : stim
    bit found;
    for (int c = 0; c < 8; c++) chan_val[c] = 12'hFFF;

    repeat (4) @(posedge clk);
    #1;
    check("rst_ss_n", {15'h0, SS_n}, 16'd1);
    check("rst_sclk", {15'h0, SCLK}, 16'd1);
    check("rst_mosi", {15'h0, MOSI}, 16'd0);
    for (int i = 0; i < 6; i++) check({"rst_", out_name[i]}, {4'h0, dut_out[i]}, 16'h000);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("start_latency", {15'h0, SS_n}, 16'd0);

    repeat (8000) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) check({"allF_", out_name[i]}, {4'h0, dut_out[i]}, 16'h0FFF);

    chan_val[1] = 12'hFFE;
    chan_val[0] = 12'hFFD;
    chan_val[4] = 12'hFFB;
    chan_val[2] = 12'hFF7;
    chan_val[3] = 12'hFEF;
    chan_val[7] = 12'hFDF;
    repeat (8000) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++)
      check({"new_", out_name[i]}, {4'h0, dut_out[i]}, {4'h0, chan_val[slot_chan[i]]});

    for (int c = 0; c < 8; c++) chan_val[c] = 12'($urandom);
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(posedge clk);
      if (SS_n === 1'b0 && txn_n[0] == 1'b1) found = 1'b1;
    end
    check("find_read_txn", {15'h0, found}, 16'd1);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_ss_n", {15'h0, SS_n}, 16'd1);
    check("async_sclk", {15'h0, SCLK}, 16'd1);
    for (int i = 0; i < 6; i++) check({"async_", out_name[i]}, {4'h0, dut_out[i]}, 16'h000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_ss_n", {15'h0, SS_n}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (8000) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++)
      check({"rand_", out_name[i]}, {4'h0, dut_out[i]}, {4'h0, chan_val[slot_chan[i]]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slide_pot_intf.md
Name: slide_pot_intf

Overview:
- SPI master that continuously polls an external 8-channel, 12-bit A2D converter (ADC128S-style) wired to six slide potentiometers.
- Reads channels round-robin and holds each latest result on a dedicated 12-bit output: the five equalizer band gains and the master volume.
- Sits between the board A2D pins and the equalizer/volume datapath.

Parameters:
- none. SCLK is fixed at clk/32.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  output  1  A2D slave select, active low.
- SCLK  output  1  SPI serial clock.
- MOSI  output  1  SPI data to the A2D.
- MISO  input  1  SPI data from the A2D.
- POT_LP  output  12  latest low-pass slider reading (A2D channel 1).
- POT_B1  output  12  band-1 reading (channel 0).
- POT_B2  output  12  band-2 reading (channel 4).
- POT_B3  output  12  band-3 reading (channel 2).
- POT_HP  output  12  high-pass reading (channel 3).
- VOLUME  output  12  volume reading (channel 7).

Behaviour:
- Reset values: SS_n=1, SCLK=1, MOSI=0, all six POT/VOLUME outputs = 12'h000, sequencer index = LP.
- Sequencer:
  - Visits LP, B1, B2, B3, HP, VOLUME in that order, then wraps back to LP.
  - Runs forever after reset and needs no external trigger.
  - The first conversion starts within 2 clocks of reset release.
- One conversion consists of two back-to-back 16-bit SPI transactions:
  - Transaction 1 shifts out the command {2'b00, ch[2:0], 11'b0}, MSB first. Data received during transaction 1 is discarded.
  - After transaction 1, SS_n returns high for at least 1 and at most 2 clk cycles.
  - Transaction 2 shifts out 16'h0000 and captures 16 MISO bits.
  - The result is bits [11:0] of the captured word. It is written to the selected output on the clk after SS_n rises at the end of transaction 2.
  - The sequencer then advances.
- SPI timing (SPI mode 3):
  - SCLK period = 32 clk cycles, 50% duty, generated by a 5-bit divider with SCLK = divider MSB.
  - SCLK idles high.
  - When SS_n falls, the divider is preloaded so the first SCLK falling edge occurs 8-16 clk cycles later (front porch).
  - MOSI changes only on SCLK falling edges. MOSI holds command bit 15 from SS_n fall until the first falling edge.
  - MISO is sampled on the clk where SCLK rises. The 16-bit shift register shifts on the following SCLK falling edge.
  - After the 16th SCLK rise, SCLK stays high and SS_n rises 8-16 clk cycles later (back porch). No extra SCLK edges occur.
- Output update rules:
  - Each output changes only at completion of its own channel's conversion. All other outputs hold.
  - A value equal to the previous value is rewritten with no glitch.
  - Full round = 6 conversions, about 1100 clk cycles each, about 6600 clk cycles per round.
- Reset asserted mid-transaction: immediately SS_n=1, SCLK=1, outputs cleared. The partial transaction is abandoned and no output is written. After release, the sequencer restarts at LP.
- MISO is only meaningful while SS_n=0. Values sampled at any other time are ignored.

Test Plan:
- Connect the A2D model with all six channels = 12'hFFF, release reset, wait 8000 clk -> all six outputs = 12'hFFF.
- Then set LP=FFE, B1=FFD, B2=FFB, B3=FF7, HP=FEF, VOL=FDF and wait 8000 clk -> each output shows its new value in the order LP..VOLUME, each at its own conversion end.
- Monitor SPI -> SCLK period 32 clk, SS_n low for exactly 16 SCLK rises per transaction, and command words 0x0800 (LP), 0x0000, 0x2000, 0x1000, 0x1800, 0x3800 in sequence.
- Check held values -> an output never changes except at completion of its own channel's conversion, and SCLK stays high whenever SS_n=1.
- Assert rst_n for 3 clk midway through a transaction -> SS_n/SCLK go high asynchronously and outputs = 0. After release, the first command is channel 1 (LP).
- Check the gap between the two transactions of one conversion -> SS_n high for 1-2 clk between transactions, and the result is taken only from the second transaction.
